dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit data words.
REQ-002 Parameter CNT_W, default 16: width of the committed-write counter.
REQ-003 Port i_clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port i_we, input, 1: write request from core for the current cycle.
REQ-006 Port i_addr, input, 32: byte address from core; word index = i_addr[log2(DEPTH)+1:2].
REQ-007 Port i_wdata, input, 32: write data from core.
REQ-008 Port o_rdata, output, 32: registered read data returned to core.
REQ-009 Port i_status, input, 2: core status code; encodings per shared define file (MIPS_END, MIPS_OVERFLOW, others).
REQ-010 Port i_status_valid, input, 1: qualifies i_status.
REQ-011 Port o_addr_err, output, 1: sticky flag for rejected write access.
REQ-012 Port o_frozen, output, 1: high in FROZEN state; memory write-protected.
REQ-013 Port o_wr_cnt, output, CNT_W: count of committed writes.
REQ-014 Port i_dbg_addr, input, log2(DEPTH): debug word index for bench/checker readout.
REQ-015 Port o_dbg_data, output, 32: combinational mem[i_dbg_addr]; no side effects.

Function
REQ-016 Access legal iff i_addr < DEPTH*4 and i_addr[1:0] == 2'b00.
REQ-017 Read: o_rdata at edge N+1 = mem[index of i_addr at edge N]; one-cycle latency, read every cycle regardless of i_we.
REQ-018 Illegal address: o_rdata loads 32'h0 on that edge.
REQ-019 Same-address read and write in same cycle: o_rdata returns old (pre-write) word.
REQ-020 Write commits at edge iff i_we=1, access legal, state RUN.
REQ-021 i_we=1 with illegal address: no memory change, o_addr_err sets at that edge, stays 1 until reset.
REQ-022 i_we=1 in FROZEN state: no memory change, o_addr_err unaffected, o_wr_cnt unchanged.
REQ-023 FSM states RUN (reset) and FROZEN; no other states.
REQ-024 RUN -> FROZEN at edge where i_status_valid=1 and i_status is MIPS_END or MIPS_OVERFLOW; FROZEN is terminal until reset.
REQ-025 Write and terminating status in same cycle: write commits (checked in RUN), freeze effective from next cycle.
REQ-026 i_status with i_status_valid=0, or other status codes: no state change.
REQ-027 o_wr_cnt increments by 1 per committed write; saturates at 2^CNT_W-1, no wrap.
REQ-028 Reads continue normally in FROZEN state.

Reset
REQ-029 i_rst_n low asynchronously: all DEPTH words = 0, o_rdata = 0, o_addr_err = 0, o_wr_cnt = 0, state RUN, o_frozen = 0.
REQ-030 Reset asserted mid-operation (including same cycle as write or freeze) discards that write/transition; state per REQ-029 while low.
REQ-031 First commit possible at first rising edge after i_rst_n deasserts.

Verification
REQ-032 Write 32'hDEADBEEF to addr 0x10, next cycle read 0x10 -> o_rdata = 32'hDEADBEEF one cycle later; o_wr_cnt = 1; o_dbg_data[4] = 32'hDEADBEEF.
REQ-033 Same cycle write 32'h1 to 0x20 (mem was 32'h5) -> o_rdata = 32'h5, following read returns 32'h1.
REQ-034 Write to 0x100 and to 0x13 -> no memory change, o_addr_err = 1 after first, o_wr_cnt unchanged, o_rdata = 0.
REQ-035 Write 32'hA to 0x4 with i_status_valid=1, i_status=MIPS_END -> mem[1]=32'hA, o_frozen=1 next cycle; later write 32'hB to 0x4 ignored, read still 32'hA.
REQ-036 CNT_W=2, 5 committed writes -> o_wr_cnt = 3.
REQ-037 Assert i_rst_n low mid-burst after 3 writes and freeze -> all words 0, o_wr_cnt = 0, o_addr_err = 0, o_frozen = 0 immediately, writes accepted after release.

Source files
------------

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Word-addressed data memory responder for a MIPS-style core.
//            Registered one-cycle reads, bounds/alignment-checked writes,
//            sticky address-error flag, saturating committed-write counter,
//            and a RUN/FROZEN state machine that write-protects memory once
//            the core reports end-of-program or overflow.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk          in   1      clock, rising edge
//   i_rst_n        in   1      asynchronous active-low reset
//   i_we           in   1      write request for this cycle
//   i_addr         in   32     byte address (word index = i_addr[AW+1:2])
//   i_wdata        in   32     write data
//   o_rdata        out  32     registered read data
//   i_status       in   2      core status code
//   i_status_valid in   1      qualifies i_status
//   o_addr_err     out  1      sticky: write to illegal address seen in RUN
//   o_frozen       out  1      memory write-protected
//   o_wr_cnt       out  CNT_W  saturating count of committed writes
//   i_dbg_addr     in   AW     debug word index
//   o_dbg_data     out  32     combinational mem[i_dbg_addr]
// ============================================================================
module dmem_responder #(
   parameter int         DEPTH         = 64,
   parameter int         CNT_W         = 16,
   parameter logic [1:0] MIPS_END      = 2'b01,
   parameter logic [1:0] MIPS_OVERFLOW = 2'b10,
   localparam int        AW            = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_we,
   input  logic [31:0]       i_addr,
   input  logic [31:0]       i_wdata,
   output logic [31:0]       o_rdata,
   input  logic [1:0]        i_status,
   input  logic              i_status_valid,
   output logic              o_addr_err,
   output logic              o_frozen,
   output logic [CNT_W-1:0]  o_wr_cnt,
   input  logic [AW-1:0]     i_dbg_addr,
   output logic [31:0]       o_dbg_data
);

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_FROZEN = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [31:0]        r_mem [DEPTH];
   logic [31:0]        r_rdata;
   logic               r_addr_err;
   logic [CNT_W-1:0]   r_wr_cnt;

   logic               w_legal;
   logic [AW-1:0]      w_idx;
   logic               w_run;
   logic               w_commit;
   logic               w_err_set;
   logic               w_terminate;

   // The full 32-bit compare catches any high address bits, so the index
   // slice below is only ever used when it is in range.
   assign w_legal     = (i_addr < 32'(DEPTH * 4)) && (i_addr[1:0] == 2'b00);
   assign w_idx       = i_addr[AW+1:2];
   assign w_run       = (r_state == ST_RUN);
   assign w_commit    = i_we && w_legal && w_run;
   // Rejected writes in FROZEN are silently dropped and do not flag an error.
   assign w_err_set   = i_we && !w_legal && w_run;
   assign w_terminate = i_status_valid &&
                        ((i_status == MIPS_END) || (i_status == MIPS_OVERFLOW));

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:    if (w_terminate) w_state_nxt = ST_FROZEN;
         ST_FROZEN: w_state_nxt = ST_FROZEN;
         default:   w_state_nxt = ST_RUN;
      endcase
   end

   // ------------------------------------------------------------- memory
   // Flop-based storage so the whole array clears on reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= 32'h0;
         end
      end else if (w_commit) begin
         r_mem[w_idx] <= i_wdata;
      end
   end

   // Read samples the pre-write contents, giving read-before-write on a
   // same-address collision.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rdata <= 32'h0;
      end else begin
         r_rdata <= w_legal ? r_mem[w_idx] : 32'h0;
      end
   end

   // ------------------------------------------------------ error / count
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_addr_err <= 1'b0;
      end else if (w_err_set) begin
         r_addr_err <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_cnt <= '0;
      end else if (w_commit && (r_wr_cnt != {CNT_W{1'b1}})) begin
         r_wr_cnt <= r_wr_cnt + 1'b1;
      end
   end

   assign o_rdata    = r_rdata;
   assign o_addr_err = r_addr_err;
   assign o_frozen   = (r_state == ST_FROZEN);
   assign o_wr_cnt   = r_wr_cnt;
   assign o_dbg_data = r_mem[i_dbg_addr];

endmodule
`default_nettype wire
